count_scheduler: RTL and testbench

COUNT_SCHEDULER -- requirements
Module: count_scheduler

---
 rtl/count_sched_pkg.sv | 11 +
 rtl/sync_counter.sv | 23 ++
 rtl/count_scheduler.sv | 122 ++++++++++++
 tb/tb_count_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/count_sched_pkg.sv
// rtl/count_sched_pkg.sv - shared types for the count scheduler
package count_sched_pkg;

    // Job lifecycle of the shared counter
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sync_counter.sv
// rtl/sync_counter.sv - up counter with synchronous clear and async active-low reset
module sync_counter #(
    parameter int WIDTH = 3
) (
    input  logic             ck,
    input  logic             clrn,
    input  logic             clear,
    input  logic             enb,
    output logic [WIDTH-1:0] q
);

    // Clear wins over count; the owner never asks for a step past its limit
    always_ff @(posedge ck or negedge clrn) begin
        if (!clrn) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (enb) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/count_scheduler.sv
// rtl/count_scheduler.sv - round-robin owner arbitration of one shared counter
module count_scheduler
    import count_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 3
) (
    input  logic                   ck,
    input  logic                   clrn,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] len,
    input  logic                   enb,
    input  logic                   abort,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [WIDTH-1:0]       cnt
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state, state_nx;
    logic [N_REQ-1:0] gnt_nx, done_nx;
    logic [PW-1:0]    ptr, ptr_nx, win;
    logic [WIDTH-1:0] limit, limit_nx;
    logic             cnt_clear, cnt_inc;
    logic [WIDTH-1:0] len_arr [N_REQ];

    // First requester found scanning upward from p, wrapping past the top index
    function automatic logic [PW-1:0] rr_select(input logic [N_REQ-1:0] r, input logic [PW-1:0] p);
        logic [PW-1:0] w;
        logic          hit;
        int            idx;
        w   = '0;
        hit = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(p) + i) % N_REQ;
            if (!hit && r[PW'(idx)]) begin
                hit = 1'b1;
                w   = PW'(idx);
            end
        end
        return w;
    endfunction

    for (genvar g = 0; g < N_REQ; g++) begin : g_len
        assign len_arr[g] = len[g*WIDTH +: WIDTH];
    end

    assign win = rr_select(req, ptr);

    // Next-state, next-output and counter control decode
    always_comb begin
        state_nx  = state;
        gnt_nx    = gnt;
        done_nx   = '0;
        ptr_nx    = ptr;
        limit_nx  = limit;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_nx    = N_REQ'(1) << win;
                    limit_nx  = len_arr[win];
                    ptr_nx    = (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
                    cnt_clear = 1'b1;
                    state_nx  = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    gnt_nx   = '0;
                    state_nx = IDLE;
                end else if (enb) begin
                    if (cnt == limit) begin
                        done_nx  = gnt;
                        state_nx = DONE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            DONE: begin
                gnt_nx   = '0;
                state_nx = IDLE;
            end
            default: begin
                gnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    // State and registered outputs; busy is precomputed so it is a flop too
    always_ff @(posedge ck or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            gnt   <= '0;
            done  <= '0;
            busy  <= 1'b0;
            ptr   <= '0;
            limit <= '0;
        end else begin
            state <= state_nx;
            gnt   <= gnt_nx;
            done  <= done_nx;
            busy  <= (state_nx != IDLE);
            ptr   <= ptr_nx;
            limit <= limit_nx;
        end
    end

    sync_counter #(.WIDTH(WIDTH)) u_cnt (
        .ck    (ck),
        .clrn  (clrn),
        .clear (cnt_clear),
        .enb   (cnt_inc),
        .q     (cnt)
    );

endmodule

// File: tb/tb_count_scheduler.sv
// tb/tb_count_scheduler.sv - scoreboard bench for count_scheduler
module tb_count_scheduler;

    localparam int N  = 4;
    localparam int W  = 3;
    localparam int LW = N * W;

    logic          ck    = 1'b0;
    logic          clrn  = 1'b1;
    logic [N-1:0]  req   = '0;
    logic [LW-1:0] len   = '0;
    logic          enb   = 1'b0;
    logic          abort = 1'b0;
    logic [N-1:0]  gnt, done;
    logic          busy;
    logic [W-1:0]  cnt;

    count_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
        .ck(ck), .clrn(clrn), .req(req), .len(len), .enb(enb), .abort(abort),
        .gnt(gnt), .done(done), .busy(busy), .cnt(cnt)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic [N-1:0] gnt;
        bit           done;
        int           cnt;
        int           run_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ptr_m  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: lowest index at or above p, else lowest below p
    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int i = p; i < N; i++)
            if (((m >> i) & 1) != 0) return i;
        for (int i = 0; i < p; i++)
            if (((m >> i) & 1) != 0) return i;
        return -1;
    endfunction

    // Monitor: follows each job the DUT presents and retires it against the scoreboard
    bit           in_job   = 0;
    logic [N-1:0] own_obs  = '0;
    logic [N-1:0] done_obs = '0;
    int           run_obs  = 0;
    int           last_cnt = 0;
    exp_t         mon_e;

    always @(negedge ck) begin
        if (!clrn) begin
            in_job   = 0;
            last_cnt = 0;
        end else if (!in_job && gnt == '0) begin
            chk("idle_cnt_hold", cnt, last_cnt);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
        end else begin
            if (!in_job) begin
                in_job   = 1;
                own_obs  = gnt;
                run_obs  = 0;
                done_obs = '0;
                chk("grant_cnt_zero", cnt, 0);
            end
            if (gnt == '0) begin
                in_job = 0;
                chk("sb_nonempty", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("owner", own_obs, mon_e.gnt);
                    chk("done_pulse", done_obs, mon_e.done ? mon_e.gnt : '0);
                    chk("final_cnt", cnt, mon_e.cnt);
                    chk("run_cycles", run_obs, mon_e.run_cyc);
                    chk("end_busy", busy, 0);
                    last_cnt = mon_e.cnt;
                end
            end else begin
                chk("gnt_stable", gnt, own_obs);
                chk("job_busy", busy, 1);
                if (done != '0) begin
                    chk("done_single", done_obs, 0);
                    done_obs = done;
                end else begin
                    run_obs++;
                end
            end
        end
    end

    // One job: grant edge, RUN cycles with chosen enb/abort pattern, optional DONE cycle.
    // scramble: 0 keep inputs, 1 randomise req/len during RUN, 2 drop req and set every len to 1.
    task automatic run_job(input logic [N-1:0] mask, input logic [LW-1:0] lens, input int enb_pct,
                           input int abort_at, input int pause_at, input int pause_len, input int scramble);
        exp_t e;
        int   w, limit, k, j, paused;
        bit   fin;
        w        = pick(mask, ptr_m);
        ptr_m    = (w + 1) % N;
        limit    = int'((lens >> (w * W)) & LW'(7));
        e.gnt    = N'(1) << w;
        e.done   = 0;
        e.cnt    = 0;
        @(negedge ck);
        req   = mask;
        len   = lens;
        enb   = 1'($urandom);
        abort = 1'($urandom);
        @(posedge ck);
        k = 0; j = 0; paused = 0; fin = 0;
        while (!fin) begin
            @(negedge ck);
            if (scramble == 1) begin
                req = N'($urandom);
                len = LW'($urandom);
            end else if (scramble == 2) begin
                req = '0;
                len = {N{3'd1}};
            end
            abort = 1'b0;
            if (pause_at == k && paused < pause_len) begin
                enb = 1'b0;
                paused++;
            end else if (j >= 60 || $urandom_range(0, 99) < enb_pct) begin
                enb = 1'b1;
            end else begin
                enb = 1'b0;
            end
            if (abort_at == k) begin
                abort = 1'b1;
                fin   = 1;
                e.cnt = k;
            end else if (enb) begin
                if (k == limit) begin
                    fin    = 1;
                    e.done = 1;
                    e.cnt  = limit;
                end else begin
                    k++;
                end
            end
            j++;
            @(posedge ck);
        end
        e.run_cyc = j;
        sb.push_back(e);
        if (e.done) begin
            @(negedge ck);
            abort = 1'($urandom);
            enb   = 1'($urandom);
            @(posedge ck);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge ck);
            req   = '0;
            abort = 1'($urandom);
            enb   = 1'($urandom);
            len   = LW'($urandom);
            @(posedge ck);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: end not reached, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ab, pa;
        #1 clrn = 1'b0;
        @(negedge ck);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", cnt, 0);
        @(negedge ck);
        clrn = 1'b1;

        repeat (5) run_job(4'b1111, '0, 100, -1, -1, 0, 0);
        run_job(4'b0001, {3'd0, 3'd0, 3'd0, 3'd3}, 100, -1, -1, 0, 0);
        idle(2);
        run_job(4'b0001, {3'd0, 3'd0, 3'd0, 3'd2}, 100, -1, 1, 2, 0);
        run_job(4'b0010, {3'd0, 3'd0, 3'd7, 3'd0}, 100, 4, -1, 0, 0);
        idle(2);
        run_job(4'b1000, {3'd7, 3'd0, 3'd0, 3'd0}, 100, -1, -1, 0, 2);
        idle(1);

        @(negedge ck);
        req   = 4'b0100;
        len   = {N{3'd7}};
        enb   = 1'b1;
        abort = 1'b0;
        ptr_m = 3;
        @(posedge ck);
        repeat (5) begin
            @(negedge ck);
            enb = 1'b1;
            req = '0;
            @(posedge ck);
        end
        @(negedge ck);
        chk("pre_reset_cnt", cnt, 5);
        chk("pre_reset_gnt", gnt, 4'b0100);
        #2 clrn = 1'b0;
        #1;
        chk("async_rst_gnt", gnt, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_cnt", cnt, 0);
        repeat (2) @(negedge ck);
        clrn  = 1'b1;
        ptr_m = 0;
        run_job(4'b1111, {3'd1, 3'd1, 3'd1, 3'd1}, 100, -1, -1, 0, 0);
        run_job(4'b0100, {3'd0, 3'd2, 3'd0, 3'd0}, 100, -1, -1, 0, 0);

        for (int t = 0; t < 40; t++) begin
            ab = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, 7)) : -1;
            pa = ($urandom_range(0, 9) < 2) ? int'($urandom_range(0, 7)) : -1;
            run_job(N'($urandom_range(1, 15)), LW'($urandom), int'($urandom_range(40, 100)),
                    ab, pa, int'($urandom_range(1, 3)), 1);
            if ($urandom_range(0, 9) < 3) idle(int'($urandom_range(1, 3)));
        end

        idle(4);
        chk("sb_empty", sb.size(), 0);
        chk("final_busy", busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
